// File: rtl/sdram_cmd_pkg.sv
// sdram_cmd_pkg: SDRAM command codes, mode-register field positions, bank state
// and read-pipe record types shared by the chip model and its testbench.
package sdram_cmd_pkg;

   // {ras, cas, we} command encodings
   localparam logic [2:0] CMD_LOAD_MODE    = 3'b000;
   localparam logic [2:0] CMD_AUTO_REFRESH = 3'b001;
   localparam logic [2:0] CMD_PRECHARGE    = 3'b010;
   localparam logic [2:0] CMD_ACTIVE       = 3'b011;
   localparam logic [2:0] CMD_WRITE        = 3'b100;
   localparam logic [2:0] CMD_READ         = 3'b101;
   localparam logic [2:0] CMD_BURST_TERM   = 3'b110;
   localparam logic [2:0] CMD_NOP          = 3'b111;

   // Mode register fields carried on sd_addr during LOAD_MODE
   localparam int unsigned MODE_CL_LSB = 4;
   localparam int unsigned MODE_CL_MSB = 6;
   localparam int unsigned MODE_BL_LSB = 0;
   localparam int unsigned MODE_BL_MSB = 2;
   localparam int unsigned MODE_WB_BIT = 9;

   // A10: auto-precharge on READ/WRITE, all-banks on PRECHARGE
   localparam int unsigned A10_BIT = 10;

   typedef enum logic {
      BankIdle = 1'b0,
      BankOpen = 1'b1
   } bank_state_e;

   // Read captured at the command edge; data arrives one cycle later from the RAM
   typedef struct packed {
      logic valid;
      logic cl3;
      logic zero;
   } rd_meta_t;

   typedef struct packed {
      logic        valid;
      logic [15:0] data;
   } rd_beat_t;

   function automatic logic cl_is_legal(input logic [2:0] cl);
      return (cl == 3'd2) || (cl == 3'd3);
   endfunction

endpackage

// File: rtl/sdram_chip_model_if.sv
// sdram_chip_model_if: controller-side SDRAM pin bundle (sd_* signals).
// master = memory controller, slave = chip model.
interface sdram_chip_model_if;
   logic        sd_cs;
   logic        sd_ras;
   logic        sd_cas;
   logic        sd_we;
   logic [1:0]  sd_ba;
   logic [12:0] sd_addr;
   logic [1:0]  sd_dqm;
   logic [15:0] sd_data_in;
   logic [15:0] sd_data_out;
   logic        sd_data_oe;

   modport master (
      output sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm, sd_data_in,
      input  sd_data_out, sd_data_oe
   );

   modport slave (
      input  sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm, sd_data_in,
      output sd_data_out, sd_data_oe
   );
endinterface

// File: rtl/sdram_model_mem.sv
// sdram_model_mem: single-port 2^AW x 16 word RAM, per-byte write enables,
// registered read. Contents are never reset.
module sdram_model_mem #(
   parameter int unsigned AW = 16
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [1:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [15:0]   wdata_i,
   output logic [15:0]   rdata_o
);

   logic [15:0] mem_q [(1 << AW)];
   logic [15:0] rdata_q;

   // Byte-enabled write and registered read of the addressed word
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
         if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_chip_model.sv
// sdram_chip_model: synthesizable responder for a 16-bit SDRAM command bus.
// Decodes commands, tracks per-bank open rows, returns read data after the
// programmed CAS latency (2 or 3). Optional protocol checker is built when
// SDRAM_MODEL_CHECK_EN is defined; otherwise proto_err is tied low.
module sdram_chip_model
   import sdram_cmd_pkg::*;
#(
   parameter int unsigned MEM_AW   = 16,
   parameter int unsigned ROW_BITS = 13,
   parameter int unsigned COL_BITS = 9
) (
   input  logic               clk,
   input  logic               reset,
   sdram_chip_model_if.slave  sd,
   output logic [15:0]        refresh_cnt,
   output logic               proto_err
);

   localparam int unsigned IdxW = 2 + ROW_BITS + COL_BITS;

   // Command decode
   logic [2:0] cmd;
   logic [1:0] ba;
   logic       a10;
   logic [2:0] cl_field;
   logic       bank_is_open;

   assign cmd          = sd.sd_cs ? CMD_NOP : {sd.sd_ras, sd.sd_cas, sd.sd_we};
   assign ba           = sd.sd_ba;
   assign a10          = sd.sd_addr[A10_BIT];
   assign cl_field     = sd.sd_addr[MODE_CL_MSB:MODE_CL_LSB];

   // State
   bank_state_e         bank_q [4];
   bank_state_e         bank_d [4];
   logic [ROW_BITS-1:0] row_q  [4];
   logic [ROW_BITS-1:0] row_d  [4];
   logic                cl3_q, cl3_d;
   logic [15:0]         ref_q, ref_d;
   rd_meta_t            s0_q, s0_d;
   rd_beat_t            s1_q, s1_d;
   rd_beat_t            out_q, out_d;

   assign bank_is_open = (bank_q[ba] == BankOpen);

   // Backing store; index is {ba,row,col} truncated to the RAM address width
   logic [IdxW-1:0]   full_idx;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_we;
   logic [15:0]       mem_rdata;
   logic [15:0]       rd_word;

   assign full_idx = {ba, row_q[ba], sd.sd_addr[COL_BITS-1:0]};
   assign mem_addr = MEM_AW'(full_idx);
   assign mem_we   = (cmd == CMD_WRITE) && bank_is_open;

   sdram_model_mem #(
      .AW (MEM_AW)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .be_i    (~sd.sd_dqm),
      .addr_i  (mem_addr),
      .wdata_i (sd.sd_data_in),
      .rdata_o (mem_rdata)
   );

   // Bank table, mode register and refresh counter next state
   always_comb begin
      bank_d = bank_q;
      row_d  = row_q;
      cl3_d  = cl3_q;
      ref_d  = ref_q;
      case (cmd)
         CMD_ACTIVE: begin
            bank_d[ba] = BankOpen;
            row_d[ba]  = sd.sd_addr[ROW_BITS-1:0];
         end
         CMD_READ, CMD_WRITE: begin
            if (a10) bank_d[ba] = BankIdle;
         end
         CMD_PRECHARGE: begin
            if (a10) begin
               for (int b = 0; b < 4; b++) bank_d[b] = BankIdle;
            end else begin
               bank_d[ba] = BankIdle;
            end
         end
         CMD_AUTO_REFRESH: ref_d = ref_q + 16'd1;
         // Illegal latencies fall back to CL2
         CMD_LOAD_MODE:    cl3_d = (cl_field == 3'd3);
         default: ;
      endcase
   end

   // Read pipe: metadata at the command edge, RAM word one edge later, then
   // either straight to the output (CL2) or through one more slot (CL3)
   always_comb begin
      s0_d.valid = (cmd == CMD_READ);
      s0_d.cl3   = cl3_q;
      s0_d.zero  = !bank_is_open;
      rd_word    = s0_q.zero ? 16'h0000 : mem_rdata;
      s1_d.valid = s0_q.valid && s0_q.cl3;
      s1_d.data  = rd_word;
      if (s0_q.valid && !s0_q.cl3) begin
         out_d.valid = 1'b1;
         out_d.data  = rd_word;
      end else if (s1_q.valid) begin
         out_d.valid = 1'b1;
         out_d.data  = s1_q.data;
      end else begin
         out_d.valid = 1'b0;
         out_d.data  = 16'h0000;
      end
   end

   // State registers; reset idles banks and flushes pending reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 4; b++) begin
            bank_q[b] <= BankIdle;
            row_q[b]  <= '0;
         end
         cl3_q <= 1'b0;
         ref_q <= 16'h0000;
         s0_q  <= '0;
         s1_q  <= '0;
         out_q <= '0;
      end else begin
         bank_q <= bank_d;
         row_q  <= row_d;
         cl3_q  <= cl3_d;
         ref_q  <= ref_d;
         s0_q   <= s0_d;
         s1_q   <= s1_d;
         out_q  <= out_d;
      end
   end

   assign sd.sd_data_out = out_q.data;
   assign sd.sd_data_oe  = out_q.valid;
   assign refresh_cnt    = ref_q;

`ifdef SDRAM_MODEL_CHECK_EN
   logic       mode_loaded_q;
   logic       err_q;
   logic [3:0] act_q;
   logic       any_open;
   logic       err_now;
   logic [2:0] bl_field;

   assign bl_field = sd.sd_addr[MODE_BL_MSB:MODE_BL_LSB];

   // Detect a protocol violation on the command sampled this edge
   always_comb begin
      any_open = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (bank_q[b] == BankOpen) any_open = 1'b1;
      end
      err_now = 1'b0;
      case (cmd)
         CMD_ACTIVE: err_now = bank_is_open || !mode_loaded_q;
         CMD_READ, CMD_WRITE: begin
            // act_q marks an ACTIVE on the previous edge (tRCD < 2)
            err_now = !bank_is_open || !mode_loaded_q || act_q[ba] ||
                      ((cmd == CMD_WRITE) && out_q.valid);
         end
         CMD_AUTO_REFRESH: err_now = any_open;
         CMD_LOAD_MODE:    err_now = !cl_is_legal(cl_field) || (bl_field != 3'b000);
         default: ;
      endcase
   end

   // Sticky error flag, mode-loaded flag and one-cycle ACTIVE history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_loaded_q <= 1'b0;
         err_q         <= 1'b0;
         act_q         <= 4'b0000;
      end else begin
         if (cmd == CMD_LOAD_MODE) mode_loaded_q <= 1'b1;
         act_q <= (cmd == CMD_ACTIVE) ? (4'b0001 << ba) : 4'b0000;
         err_q <= err_q | err_now;
      end
   end

   assign proto_err = err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_chip_model.sv
// tb_sdram_chip_model: scoreboard bench for sdram_chip_model. Read expectations
// (data and due cycle) are queued when a READ is driven and checked when the
// model drives a beat. Expected proto_err follows SDRAM_MODEL_CHECK_EN.
module tb_sdram_chip_model;
   import sdram_cmd_pkg::*;

`ifdef SDRAM_MODEL_CHECK_EN
   localparam bit CheckEn = 1'b1;
`else
   localparam bit CheckEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] refresh_cnt;
   logic        proto_err;

   sdram_chip_model_if sd_if ();

   sdram_chip_model dut (
      .clk         (clk),
      .reset       (reset),
      .sd          (sd_if),
      .refresh_cnt (refresh_cnt),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks  = 0;
   int n_fail    = 0;
   int oe_cycles = 0;
   int beats_exp = 0;
   int tb_cl     = 2;
   int oe_before = 0;

   logic [15:0] exp_data_q [$];
   int          exp_due_q  [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Beat monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (sd_if.sd_data_oe === 1'b1) begin
         oe_cycles++;
         if (exp_data_q.size() == 0) begin
            check_eq("unexpected_beat_queue", 32'(exp_data_q.size()), 32'd1);
         end else begin
            logic [15:0] d;
            int          due;
            d   = exp_data_q.pop_front();
            due = exp_due_q.pop_front();
            check_eq("beat_data", 32'(sd_if.sd_data_out), 32'(d));
            check_eq("beat_cycle", 32'(cyc), 32'(due));
         end
      end
   end

   task automatic bus_cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                          input logic [15:0] din, input logic [1:0] dqm);
      sd_if.sd_cs = 1'b0;
      {sd_if.sd_ras, sd_if.sd_cas, sd_if.sd_we} = c;
      sd_if.sd_ba      = ba;
      sd_if.sd_addr    = addr;
      sd_if.sd_data_in = din;
      sd_if.sd_dqm     = dqm;
      @(posedge clk);
      #1;
      sd_if.sd_cs = 1'b1;
      {sd_if.sd_ras, sd_if.sd_cas, sd_if.sd_we} = CMD_NOP;
   endtask

   task automatic nop(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sd_write(input logic [1:0] ba, input logic [8:0] col, input logic [15:0] din,
                           input logic [1:0] dqm);
      bus_cmd(CMD_WRITE, ba, {4'b0000, col}, din, dqm);
   endtask

   task automatic sd_read(input logic [1:0] ba, input logic [8:0] col, input logic a10,
                          input logic [15:0] exp);
      bus_cmd(CMD_READ, ba, {2'b00, a10, 1'b0, col}, 16'h0000, 2'b00);
      exp_data_q.push_back(exp);
      exp_due_q.push_back(cyc + tb_cl - 1);
      beats_exp++;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_data_q.size() != 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      check_eq("drain_pending", 32'(exp_data_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      sd_if.sd_cs      = 1'b1;
      sd_if.sd_ras     = 1'b1;
      sd_if.sd_cas     = 1'b1;
      sd_if.sd_we      = 1'b1;
      sd_if.sd_ba      = 2'b00;
      sd_if.sd_addr    = 13'h0000;
      sd_if.sd_data_in = 16'h0000;
      sd_if.sd_dqm     = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check_eq("reset_oe", 32'(sd_if.sd_data_oe), 32'd0);
      check_eq("reset_dout", 32'(sd_if.sd_data_out), 32'd0);
      check_eq("reset_refcnt", 32'(refresh_cnt), 32'd0);
      check_eq("reset_perr", 32'(proto_err), 32'd0);

      // CL2 write then read-after-write
      bus_cmd(CMD_LOAD_MODE, 2'd0, 13'h220, 16'h0, 2'b00);
      tb_cl = 2;
      bus_cmd(CMD_ACTIVE, 2'd0, 13'h005, 16'h0, 2'b00);
      nop(1);
      sd_write(2'd0, 9'h012, 16'hA55A, 2'b00);
      sd_read(2'd0, 9'h012, 1'b0, 16'hA55A);
      drain();
      check_eq("t1_perr", 32'(proto_err), 32'd0);

      // CL3, three back-to-back reads
      bus_cmd(CMD_LOAD_MODE, 2'd0, 13'h230, 16'h0, 2'b00);
      tb_cl = 3;
      sd_write(2'd0, 9'h020, 16'h1111, 2'b00);
      sd_write(2'd0, 9'h021, 16'h2222, 2'b00);
      sd_write(2'd0, 9'h022, 16'h3333, 2'b00);
      sd_read(2'd0, 9'h020, 1'b0, 16'h1111);
      sd_read(2'd0, 9'h021, 1'b0, 16'h2222);
      sd_read(2'd0, 9'h022, 1'b0, 16'h3333);
      drain();

      // Byte masks
      sd_write(2'd0, 9'h030, 16'hA55A, 2'b00);
      sd_write(2'd0, 9'h030, 16'h1234, 2'b10);
      sd_read(2'd0, 9'h030, 1'b0, 16'hA534);
      drain();
      sd_write(2'd0, 9'h030, 16'h1234, 2'b01);
      sd_read(2'd0, 9'h030, 1'b0, 16'h1234);
      drain();
      check_eq("t3_perr", 32'(proto_err), 32'd0);

      // Refresh with all banks idle
      bus_cmd(CMD_PRECHARGE, 2'd0, 13'h400, 16'h0, 2'b00);
      repeat (3) bus_cmd(CMD_AUTO_REFRESH, 2'd0, 13'h000, 16'h0, 2'b00);
      nop(1);
      check_eq("t5_refcnt3", 32'(refresh_cnt), 32'd3);
      check_eq("t5_perr_idle", 32'(proto_err), 32'd0);

      // Auto-precharge read, then read to the now idle bank
      bus_cmd(CMD_ACTIVE, 2'd0, 13'h005, 16'h0, 2'b00);
      nop(1);
      sd_write(2'd0, 9'h040, 16'hBEEF, 2'b00);
      sd_read(2'd0, 9'h040, 1'b1, 16'hBEEF);
      sd_read(2'd0, 9'h040, 1'b0, 16'h0000);
      drain();
      check_eq("t4_perr", 32'(proto_err), 32'(CheckEn));

      // Refresh with bank 1 open
      bus_cmd(CMD_ACTIVE, 2'd1, 13'h007, 16'h0, 2'b00);
      nop(1);
      bus_cmd(CMD_AUTO_REFRESH, 2'd0, 13'h000, 16'h0, 2'b00);
      nop(1);
      check_eq("t5_refcnt4", 32'(refresh_cnt), 32'd4);
      check_eq("t5_perr_open", 32'(proto_err), 32'(CheckEn));

      // Reset one cycle after a CL3 read: beat must never appear
      bus_cmd(CMD_ACTIVE, 2'd0, 13'h005, 16'h0, 2'b00);
      nop(2);
      bus_cmd(CMD_READ, 2'd0, 13'h012, 16'h0, 2'b00);
      nop(1);
      oe_before = oe_cycles;
      reset = 1'b1;
      nop(3);
      check_eq("t6_oe_in_reset", 32'(sd_if.sd_data_oe), 32'd0);
      check_eq("t6_dout_in_reset", 32'(sd_if.sd_data_out), 32'd0);
      check_eq("t6_refcnt", 32'(refresh_cnt), 32'd0);
      check_eq("t6_perr", 32'(proto_err), 32'd0);
      reset = 1'b0;
      nop(3);
      check_eq("t6_no_beat", 32'(oe_cycles), 32'(oe_before));

      // RAM survives reset; mode is back to CL2 until reloaded
      bus_cmd(CMD_LOAD_MODE, 2'd0, 13'h220, 16'h0, 2'b00);
      tb_cl = 2;
      bus_cmd(CMD_ACTIVE, 2'd0, 13'h005, 16'h0, 2'b00);
      nop(1);
      sd_read(2'd0, 9'h012, 1'b0, 16'hA55A);
      drain();
      check_eq("t6_perr_after", 32'(proto_err), 32'd0);
      check_eq("oe_cycle_total", 32'(oe_cycles), 32'(beats_exp));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
